// File: rtl/cpu_io_port_pkg.sv
// Shared constants for the CPU I/O port: defaults, presenter state encodings, helpers.
package cpu_io_port_pkg;

  localparam int unsigned DEF_WIDTH       = 10;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_HOLD_CYCLES = 25;

  typedef logic [1:0] pres_state_t;

  localparam pres_state_t ST_IDLE    = 2'd0;
  localparam pres_state_t ST_HOLD    = 2'd1;
  localparam pres_state_t ST_STARVED = 2'd2;

  // Hold counter width: must be able to represent 0..hold
  function automatic int unsigned cnt_width(input int unsigned hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/cpu_io_port_sync_fifo.sv
// First-word-fall-through synchronous FIFO; caller qualifies push/pop against full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cpu_io_port.sv
// Device end of the CPU DataIn/DataOut port: paced word presenter plus DataOut change queue.
module cpu_io_port
  import cpu_io_port_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] DataIn,
  output logic             InStarved,
  input  logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutOverflow
);

  localparam int unsigned      CNT_W    = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Input queue signals
  logic             w_in_push;
  logic             w_in_pop;
  logic [WIDTH-1:0] w_in_head;
  logic             w_in_full;
  logic             w_in_empty;

  // Output queue signals
  logic             w_out_push;
  logic             w_out_pop;
  logic             w_out_full;
  logic             w_out_empty;
  logic             w_dout_change;

  // Presenter state
  pres_state_t      r_state;
  pres_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_data_in;
  logic [WIDTH-1:0] w_data_in_nxt;
  logic             r_in_starved;

  // Change detector and overflow state
  logic [WIDTH-1:0] r_dout_q;
  logic             r_overflow;

  // Ready reflects fullness before any same-cycle pop
  assign w_in_push = InValid && !w_in_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_in_push),
    .i_data  (InData),
    .i_pop   (w_in_pop),
    .o_data  (w_in_head),
    .o_full  (w_in_full),
    .o_empty (w_in_empty)
  );

  // Presenter next-state: load a word when idle, starved, or at the end of a hold
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_in_nxt = r_data_in;
    w_in_pop      = 1'b0;
    case (r_state)
      ST_IDLE, ST_STARVED: begin
        if (!w_in_empty) begin
          w_in_pop      = 1'b1;
          w_data_in_nxt = w_in_head;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == CNT_LAST) begin
          if (!w_in_empty) begin
            w_in_pop      = 1'b1;
            w_data_in_nxt = w_in_head;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = ST_STARVED;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Presenter registers; InStarved tracks the STARVED state exactly
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_data_in    <= '0;
      r_in_starved <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data_in    <= w_data_in_nxt;
      r_in_starved <= (w_state_nxt == ST_STARVED);
    end
  end

  // A full queue still accepts a change when the host drains one in the same cycle
  assign w_dout_change = (DataOut != r_dout_q);
  assign w_out_pop     = OutReady && !w_out_empty;
  assign w_out_push    = w_dout_change && (!w_out_full || w_out_pop);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_out_push),
    .i_data  (DataOut),
    .i_pop   (w_out_pop),
    .o_data  (OutData),
    .o_full  (w_out_full),
    .o_empty (w_out_empty)
  );

  // Previous DataOut sample and sticky overflow on a dropped change
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_dout_q   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_dout_q <= DataOut;
      if (w_dout_change && w_out_full && !w_out_pop) r_overflow <= 1'b1;
    end
  end

  assign InReady     = !w_in_full;
  assign DataIn      = r_data_in;
  assign InStarved   = r_in_starved;
  assign OutValid    = !w_out_empty;
  assign OutOverflow = r_overflow;

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed bench for cpu_io_port with default parameters (WIDTH=10, DEPTH=8, HOLD_CYCLES=25).
module tb_cpu_io_port;

  localparam int unsigned W = 10;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] InData;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] DataIn;
  logic         InStarved;
  logic [W-1:0] DataOut;
  logic [W-1:0] OutData;
  logic         OutValid;
  logic         OutReady;
  logic         OutOverflow;

  int checks;
  int failures;

  cpu_io_port dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InData      (InData),
    .InValid     (InValid),
    .InReady     (InReady),
    .DataIn      (DataIn),
    .InStarved   (InStarved),
    .DataOut     (DataOut),
    .OutData     (OutData),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutOverflow (OutOverflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] dout;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } out_vec_t;

  out_vec_t vecs [8];

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    InValid  = 1'b0;
    InData   = '0;
    OutReady = 1'b0;
    DataOut  = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] exp_di;
    checks   = 0;
    failures = 0;

    // DataOut stream 0,5,5,7,7,7,0 with the host always ready
    vecs[0] = '{dout: 10'd0, ready: 1'b1, exp_valid: 1'b0, exp_data: 10'd0, exp_ovf: 1'b0};
    vecs[1] = '{dout: 10'd5, ready: 1'b1, exp_valid: 1'b1, exp_data: 10'd5, exp_ovf: 1'b0};
    vecs[2] = '{dout: 10'd5, ready: 1'b1, exp_valid: 1'b0, exp_data: 10'd0, exp_ovf: 1'b0};
    vecs[3] = '{dout: 10'd7, ready: 1'b1, exp_valid: 1'b1, exp_data: 10'd7, exp_ovf: 1'b0};
    vecs[4] = '{dout: 10'd7, ready: 1'b1, exp_valid: 1'b0, exp_data: 10'd0, exp_ovf: 1'b0};
    vecs[5] = '{dout: 10'd7, ready: 1'b1, exp_valid: 1'b0, exp_data: 10'd0, exp_ovf: 1'b0};
    vecs[6] = '{dout: 10'd0, ready: 1'b1, exp_valid: 1'b1, exp_data: 10'd0, exp_ovf: 1'b0};
    vecs[7] = '{dout: 10'd0, ready: 1'b1, exp_valid: 1'b0, exp_data: 10'd0, exp_ovf: 1'b0};

    // Reset state
    do_reset();
    chk("rst_datain", 32'(DataIn), 32'd0);
    chk("rst_starved", 32'(InStarved), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_overflow", 32'(OutOverflow), 32'd0);

    // Test 1: paced presentation of 10,13,16 then starvation
    InValid = 1'b1;
    InData  = 10'd10;
    step();
    chk("t1_push_edge", 32'(DataIn), 32'd0);
    InData = 10'd13;
    step();
    chk("t1_first_word", 32'(DataIn), 32'd10);
    InData = 10'd16;
    step();
    chk("t1_k1", 32'(DataIn), 32'd10);
    InValid = 1'b0;
    for (int k = 2; k < 80; k++) begin
      step();
      if (k < 25)      exp_di = 10'd10;
      else if (k < 50) exp_di = 10'd13;
      else             exp_di = 10'd16;
      chk($sformatf("t1_datain_k%0d", k), 32'(DataIn), 32'(exp_di));
      chk($sformatf("t1_starved_k%0d", k), 32'(InStarved), (k >= 75) ? 32'd1 : 32'd0);
    end

    // Test 2: fill the input queue while the presenter holds
    do_reset();
    InValid = 1'b1;
    InData  = 10'd100;
    step();
    for (int j = 1; j <= 8; j++) begin
      InData = 10'(100 + j);
      step();
    end
    chk("t2_full_inready", 32'(InReady), 32'd0);
    chk("t2_holding", 32'(DataIn), 32'd100);
    InData = 10'd109;
    for (int j = 0; j < 17; j++) begin
      step();
      chk($sformatf("t2_blocked_%0d", j), 32'(InReady), 32'd0);
    end
    step();
    chk("t2_pop_word", 32'(DataIn), 32'd101);
    chk("t2_ready_after_pop", 32'(InReady), 32'd1);
    step();
    InValid = 1'b0;
    chk("t2_accept_full_again", 32'(InReady), 32'd0);
    for (int j = 2; j <= 9; j++) begin
      for (int c = 0; c < 25; c++) step();
      chk($sformatf("t2_word_%0d", j), 32'(DataIn), 32'(100 + j));
    end

    // Test 3: table-driven change capture
    do_reset();
    for (int i = 0; i < 8; i++) begin
      DataOut  = vecs[i].dout;
      OutReady = vecs[i].ready;
      step();
      chk($sformatf("t3_valid_%0d", i), 32'(OutValid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("t3_data_%0d", i), 32'(OutData), 32'(vecs[i].exp_data));
      chk($sformatf("t3_ovf_%0d", i), 32'(OutOverflow), 32'(vecs[i].exp_ovf));
    end

    // Test 4: nine changes into an undrained queue
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      DataOut = 10'(v);
      step();
      chk($sformatf("t4_ovf_%0d", v), 32'(OutOverflow), (v == 9) ? 32'd1 : 32'd0);
    end
    OutReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t4_valid_%0d", k), 32'(OutValid), 32'd1);
      chk($sformatf("t4_data_%0d", k), 32'(OutData), 32'(k));
      step();
    end
    chk("t4_empty", 32'(OutValid), 32'd0);
    chk("t4_sticky", 32'(OutOverflow), 32'd1);

    // Test 5: push and pop together on a full output queue
    do_reset();
    for (int v = 0; v < 8; v++) begin
      DataOut = 10'(20 + v);
      step();
    end
    chk("t5_full_noovf", 32'(OutOverflow), 32'd0);
    chk("t5_head", 32'(OutData), 32'd20);
    OutReady = 1'b1;
    DataOut  = 10'd28;
    step();
    OutReady = 1'b0;
    chk("t5_pushpop_noovf", 32'(OutOverflow), 32'd0);
    chk("t5_head_after", 32'(OutData), 32'd21);
    DataOut = 10'd29;
    step();
    chk("t5_still_full", 32'(OutOverflow), 32'd1);
    OutReady = 1'b1;
    for (int k = 21; k <= 28; k++) begin
      chk($sformatf("t5_data_%0d", k), 32'(OutData), 32'(k));
      step();
    end
    chk("t5_empty", 32'(OutValid), 32'd0);

    // Test 6: reset in the middle of a hold with both queues occupied
    do_reset();
    InValid = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      InData = 10'(j);
      step();
    end
    InValid = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      DataOut = 10'(v + 40);
      step();
    end
    chk("t6_pre_datain", 32'(DataIn), 32'd1);
    chk("t6_pre_ovf", 32'(OutOverflow), 32'd1);
    Reset   = 1'b1;
    DataOut = '0;
    step();
    chk("t6_datain", 32'(DataIn), 32'd0);
    chk("t6_outvalid", 32'(OutValid), 32'd0);
    chk("t6_inready", 32'(InReady), 32'd1);
    chk("t6_ovf", 32'(OutOverflow), 32'd0);
    chk("t6_starved", 32'(InStarved), 32'd0);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t6_idle_datain_%0d", c), 32'(DataIn), 32'd0);
      chk($sformatf("t6_idle_outvalid_%0d", c), 32'(OutValid), 32'd0);
    end
    DataOut = 10'd7;
    InValid = 1'b1;
    InData  = 10'd55;
    step();
    InValid = 1'b0;
    chk("t6_first_nonzero_valid", 32'(OutValid), 32'd1);
    chk("t6_first_nonzero_data", 32'(OutData), 32'd7);
    step();
    chk("t6_latency", 32'(DataIn), 32'd55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
